// File: rtl/state_seq_checker.sv
// ---------------------------------------------------------------------------
// state_seq_checker
//   Monitor for a cyclic state sequencer (0 -> 1 -> ... -> all-ones -> 0).
//   It captures the first valid sample, then counts consecutive legal
//   increments. After LOCK_N of them it reports locked. While locked, any
//   illegal transition produces a one-cycle err_pulse, bumps err_count and
//   drops back to searching. Each legal all-ones -> 0 step while locked bumps
//   wrap_count. Both counters saturate at all-ones.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high; clears all state
//   clr         in   synchronous clear of err_count / wrap_count only
//   in_valid    in   in_state holds a sample this cycle
//   in_state    in   observed state value [STATE_W-1:0]
//   locked      out  sequence tracked and legal
//   err_pulse   out  one-cycle pulse on an illegal transition while locked
//   err_count   out  saturating error count [CNT_W-1:0]
//   wrap_count  out  saturating wrap count [CNT_W-1:0]
//   exp_state   out  value expected at the next valid sample [STATE_W-1:0]
//   dbg_state   out  FSM state (0 IDLE, 1 SEARCH, 2 LOCKED)
//
// Handshake: there is no back-pressure. A sample is consumed on every rising
// edge where in_valid is high; all outputs reflect it one cycle later.
// ---------------------------------------------------------------------------
module state_seq_checker #(
  parameter int STATE_W = 2,
  parameter int LOCK_N  = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [STATE_W-1:0] in_state,
  output logic               locked,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   wrap_count,
  output logic [STATE_W-1:0] exp_state,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int RUN_W = 4;  // LOCK_N is limited to 1..15
  localparam logic [STATE_W-1:0] STATE_ALL1 = '1;
  localparam logic [CNT_W-1:0]   CNT_ALL1   = '1;

  state_t             r_state;
  logic [STATE_W-1:0] r_prev;
  logic [RUN_W-1:0]   r_good_run;

  logic               w_match;
  logic               w_err_inc;
  logic               w_wrap_inc;
  logic [RUN_W-1:0]   w_run_next;

  // A repeated value never equals prev+1, so a stalled sequencer mismatches.
  always_comb begin
    w_match    = (in_state == exp_state);
    w_run_next = r_good_run + RUN_W'(1);
    w_err_inc  = 1'b0;
    w_wrap_inc = 1'b0;
    if (in_valid && (r_state == LOCKED)) begin
      w_err_inc  = !w_match;
      w_wrap_inc = w_match && (r_prev == STATE_ALL1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prev     <= '0;
      r_good_run <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      exp_state  <= '0;
    end else begin
      err_pulse <= 1'b0;

      if (in_valid) begin
        // Every sample becomes the new reference, legal or not.
        r_prev    <= in_state;
        exp_state <= in_state + STATE_W'(1);

        case (r_state)
          IDLE: begin
            // First sample after reset is a capture only.
            r_good_run <= '0;
            r_state    <= SEARCH;
          end
          SEARCH: begin
            if (w_match) begin
              r_good_run <= w_run_next;
              if (w_run_next == RUN_W'(LOCK_N)) begin
                r_state <= LOCKED;
                locked  <= 1'b1;
              end
            end else begin
              r_good_run <= '0;
            end
          end
          LOCKED: begin
            if (!w_match) begin
              err_pulse  <= 1'b1;
              locked     <= 1'b0;
              r_good_run <= '0;
              r_state    <= SEARCH;
            end
          end
          default: begin
            r_state    <= IDLE;
            locked     <= 1'b0;
            r_good_run <= '0;
          end
        endcase
      end

      // clr has priority over a same-cycle increment.
      if (clr) begin
        err_count <= '0;
      end else if (w_err_inc && (err_count != CNT_ALL1)) begin
        err_count <= err_count + CNT_W'(1);
      end

      if (clr) begin
        wrap_count <= '0;
      end else if (w_wrap_inc && (wrap_count != CNT_ALL1)) begin
        wrap_count <= wrap_count + CNT_W'(1);
      end
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_state_seq_checker.sv
module tb_state_seq_checker;

  localparam int STATE_W = 2;
  localparam int LOCK_N  = 4;
  localparam int CNT_W   = 8;
  localparam int VW      = 2 + 2 * CNT_W + STATE_W;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic [STATE_W-1:0] in_state = '0;
  logic               locked;
  logic               err_pulse;
  logic [CNT_W-1:0]   err_count;
  logic [CNT_W-1:0]   wrap_count;
  logic [STATE_W-1:0] exp_state;
  logic [1:0]         dbg_state;

  always #5 clk = ~clk;

  state_seq_checker #(.STATE_W(STATE_W), .LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_state(in_state),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .wrap_count(wrap_count), .exp_state(exp_state), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every cycle's outputs are checked against the queued expectation.
  always @(posedge clk) begin
    logic [VW-1:0] e;
    logic [VW-1:0] a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {locked, err_pulse, err_count, wrap_count, exp_state};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL cycle_outputs actual{lk,ep,err,wrap,exp}=%0h/%0h/%0h/%0h/%0h expected=%0h/%0h/%0h/%0h/%0h at %0t",
                 a[VW-1], a[VW-2], a[VW-3 -: CNT_W], a[STATE_W +: CNT_W], a[STATE_W-1:0],
                 e[VW-1], e[VW-2], e[VW-3 -: CNT_W], e[STATE_W +: CNT_W], e[STATE_W-1:0], $time);
      end
    end
  end

  // ---------------- reference model ----------------
  // Abstract view: remember the last sample, count consecutive legal +1 steps.
  bit m_have;
  int m_prev;
  int m_run;
  bit m_locked;
  bit m_pulse;
  int m_err;
  int m_wrap;
  localparam int MOD  = 1 << STATE_W;
  localparam int CMAX = (1 << CNT_W) - 1;

  task automatic m_reset();
    m_have = 0; m_prev = 0; m_run = 0; m_locked = 0; m_pulse = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic m_step(input bit v, input int s, input bit c);
    bit legal;
    m_pulse = 0;
    if (v) begin
      if (m_have) begin
        legal = (s == (m_prev + 1) % MOD);
        if (m_locked) begin
          if (legal) begin
            if (s == 0 && m_wrap < CMAX) m_wrap++;
          end else begin
            m_pulse = 1; m_locked = 0; m_run = 0;
            if (m_err < CMAX) m_err++;
          end
        end else if (legal) begin
          m_run++;
          if (m_run == LOCK_N) m_locked = 1;
        end else begin
          m_run = 0;
        end
      end
      m_have = 1;
      m_prev = s;
    end
    if (c) begin m_err = 0; m_wrap = 0; end
  endtask

  function automatic logic [VW-1:0] m_vec();
    logic [STATE_W-1:0] e;
    e = m_have ? STATE_W'((m_prev + 1) % MOD) : '0;
    return {m_locked, m_pulse, CNT_W'(m_err), CNT_W'(m_wrap), e};
  endfunction

  // ---------------- driver tasks ----------------
  logic [STATE_W-1:0] cur = '0;

  task automatic step(input bit v, input logic [STATE_W-1:0] s, input bit c);
    @(negedge clk);
    in_valid = v; in_state = s; clr = c;
    m_step(v, int'(s), c);
    exp_q.push_back(m_vec());
    @(posedge clk);
  endtask

  task automatic good(input int n);
    for (int i = 0; i < n; i++) begin
      cur = cur + 1'b1;
      step(1'b1, cur, 1'b0);
    end
  endtask

  // Repeating the last value is always illegal.
  task automatic bad(input bit c);
    step(1'b1, cur, c);
  endtask

  task automatic spot(input string name, input logic [31:0] act, input logic [31:0] expv);
    check(name, act, expv);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_err_pulse"}, 32'(err_pulse), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
    check({tag, "_wrap_count"}, 32'(wrap_count), 0);
    check({tag, "_exp_state"}, 32'(exp_state), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1 check_cleared("reset");
    @(negedge clk) reset = 1'b0;

    // T1: 0,1,2,3,0 -> locked after the fifth sample
    cur = '0;
    step(1'b1, cur, 1'b0);
    good(3);
    #2 spot("t1_not_yet_locked", 32'(locked), 0);
    good(1);
    #2 spot("t1_locked", 32'(locked), 1);
    spot("t1_err", 32'(err_count), 0);
    spot("t1_wrap", 32'(wrap_count), 0);

    // T2: 1,2,3,0,1 -> one wrap, expect 2 next
    good(5);
    #2 spot("t2_wrap", 32'(wrap_count), 1);
    spot("t2_exp", 32'(exp_state), 2);

    // T3: illegal 0 while expecting 2
    cur = '0;
    step(1'b1, cur, 1'b0);
    #2 spot("t3_pulse", 32'(err_pulse), 1);
    spot("t3_err", 32'(err_count), 1);
    spot("t3_locked", 32'(locked), 0);
    spot("t3_exp", 32'(exp_state), 1);
    step(1'b0, 2'd0, 1'b0);
    #2 spot("t3_pulse_drop", 32'(err_pulse), 0);
    good(4);
    #2 spot("t3_relock", 32'(locked), 1);

    // T4: valid pattern 1,0,0,1 with garbage on the bus during gaps
    for (int k = 0; k < 3; k++) begin
      good(1);
      step(1'b0, 2'($urandom_range(0, 3)), 1'b0);
      step(1'b0, 2'($urandom_range(0, 3)), 1'b0);
      good(1);
    end
    #2 spot("t4_locked", 32'(locked), 1);
    spot("t4_err", 32'(err_count), 1);

    // T5: saturate err_count
    for (int k = 0; k < 254; k++) begin
      bad(1'b0);
      good(4);
    end
    #2 spot("t5_err_255", 32'(err_count), 255);
    bad(1'b0);
    #2 spot("t5_sat_pulse", 32'(err_pulse), 1);
    spot("t5_sat_hold", 32'(err_count), 255);
    good(4);
    bad(1'b1);
    #2 spot("t5_clr_pulse", 32'(err_pulse), 1);
    spot("t5_clr_wins", 32'(err_count), 0);
    good(4);

    // T6: async reset while locked
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    #2 reset = 1'b1;
    #1 check_cleared("t6_async");
    m_reset();
    @(negedge clk) reset = 1'b0;
    cur = 2'd2;
    step(1'b1, cur, 1'b0);
    #2 spot("t6_capture_no_err", 32'(err_pulse), 0);
    spot("t6_exp", 32'(exp_state), 3);
    good(4);
    #2 spot("t6_relock", 32'(locked), 1);

    // Random phase: mostly legal traffic, gaps, illegal jumps, clr
    for (int k = 0; k < 1500; k++) begin
      int r;
      bit c;
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 49) == 0);
      if (r < 20) begin
        step(1'b0, 2'($urandom_range(0, 3)), c);
      end else if (r < 30) begin
        cur = 2'($urandom_range(0, 3));
        step(1'b1, cur, c);
      end else begin
        cur = cur + 1'b1;
        step(1'b1, cur, c);
      end
    end

    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #2 check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
